seg7_scanner: RTL
=================

SEG7_SCANNER -- requirements
Module: seg7_scanner

Interface
REQ-001 Parameter DIGITS, default 8: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 100000: clock cycles each digit stays enabled, legal range >= 2.
REQ-003 Parameter LZ_BLANK, default 1: 1 enables leading-zero blanking, 0 shows all digits.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that enters the scanning state and latches value_in.
REQ-007 blank  input  1  one-cycle pulse that returns to the idle state with all digits off.
REQ-008 load  input  1  one-cycle pulse that captures value_in into the shadow register while scanning.
REQ-009 value_in  input  4*DIGITS  hex nibbles; nibble k drives digit k, with digit 0 as the least-significant nibble.
REQ-010 dp_in  input  DIGITS  decimal-point request per digit, active-high, sampled with value_in.
REQ-011 led_en  output  DIGITS  digit enables, active-low, registered.
REQ-012 seg  output  7  segments, active-low, registered; seg[0]=a through seg[6]=g.
REQ-013 led_dp  output  1  decimal point, active-low, registered.
REQ-014 scanning  output  1  high while in SCAN.

Function
REQ-015 The block SHALL have two states: IDLE and SCAN.
REQ-016 In IDLE the block SHALL drive led_en all 1s, seg = 7'h7F, led_dp = 1 and scanning = 0.
REQ-017 IDLE->SCAN on start SHALL latch value_in and dp_in into both the display and shadow registers, set digit index 0, and clear the dwell counter.
REQ-018 In SCAN, the cycle after start SHALL show led_en with only bit 0 low and seg/led_dp for nibble 0.
REQ-019 Each digit SHALL stay enabled for exactly SCAN_DIV cycles.
REQ-020 The digit index SHALL then advance by 1, wrapping from DIGITS-1 to 0; exactly one led_en bit is low at any time in SCAN.
REQ-021 seg, led_dp and led_en SHALL change on the same clock edge, with no cycle in which the enable and the segments belong to different digits.
REQ-022 Hex encoding (gfedcba, active-low) SHALL be: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:18 A:08 B:03 C:27 D:21 E:06 F:0E.
REQ-023 load in SCAN SHALL update only the shadow register.
REQ-024 Shadow SHALL copy to the display register at the wrap from DIGITS-1 to 0, so each frame is coherent.
REQ-025 Multiple loads within one frame SHALL leave only the last one effective.
REQ-026 load in IDLE SHALL update the shadow register only; the next start overrides it with value_in.
REQ-027 With LZ_BLANK=1, a digit k above the highest nonzero nibble SHALL keep its enable bit 1 and drive seg = 7'h7F during its slot; timing SHALL be unchanged.
REQ-028 Digit 0 SHALL never be blanked, so a value of 0 shows a single "0".
REQ-029 A dp_in bit set on a blanked digit SHALL NOT light the decimal point.
REQ-030 start while in SCAN SHALL restart the scan: index 0, counter cleared, value_in latched into both registers.
REQ-031 blank in SCAN SHALL enter IDLE the next cycle.
REQ-032 If start and blank arrive in the same cycle, blank SHALL take priority.
REQ-033 If load and start arrive in the same cycle, start semantics SHALL apply.

Reset
REQ-034 rst SHALL immediately, without waiting for clk, force IDLE, led_en all 1s, seg = 7'h7F, led_dp = 1, scanning = 0, index 0, counter 0, and display/shadow = 0.
REQ-035 Deassertion of rst SHALL leave the block in IDLE until a start arrives; reset mid-scan SHALL behave identically.

Verification (DIGITS=8, SCAN_DIV=4)
REQ-036 Reset then no start -> led_en=8'hFF, seg=7'h7F, led_dp=1 indefinitely.
REQ-037 LZ_BLANK=0, value_in=32'h89ABCDEF, start -> led_en steps FE,FD,FB,...,7F every 4 cycles with seg 0E,06,21,27,03,08,18,00, then wraps to FE.
REQ-038 LZ_BLANK=1, value_in=32'h00000305, dp_in=8'h02 -> digits 0..2 show 12,40,30 with led_dp=0 only on digit 1; slots 3..7 keep led_en=FF and seg=7F.
REQ-039 Mid-frame load of 32'h00000001 followed by 32'h00000002 -> current frame unchanged; from the next digit-0 slot only "2" is shown.
REQ-040 start and blank pulsed in the same cycle during SCAN -> IDLE outputs on the next cycle.
REQ-041 rst asserted mid-scan, asynchronous to clk -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/seg7_scanner.sv
// seg7_scanner: multiplexed hex 7-segment driver with a per-frame shadow register
// and optional leading-zero blanking. All display outputs are registered and
// change together, so an enable never pairs with another digit's segments.
module seg7_scanner #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned LZ_BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  blank,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [DIGITS-1:0]     led_en,
  output logic [6:0]            seg,
  output logic                  led_dp,
  output logic                  scanning
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(SCAN_DIV);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [VW-1:0]     disp_val_q, disp_val_d;
  logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [VW-1:0]     sh_val_q, sh_val_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DIGITS-1:0] led_en_d;
  logic [6:0]        seg_d;
  logic              led_dp_d;
  logic              scanning_d;
  logic [3:0]        nib;
  logic              lz;

  // Hex nibble to active-low gfedcba pattern
  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // True when digit k and every digit above it are zero (digit 0 never qualifies)
  function automatic logic lead_zero(input logic [VW-1:0] v, input logic [IW-1:0] k);
    logic nz;
    nz = 1'b0;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      if (j >= 32'(k) && v[4*j +: 4] != 4'h0) nz = 1'b1;
    end
    return (k != '0) && !nz;
  endfunction

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d    = state_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    sh_val_d   = sh_val_q;
    sh_dp_d    = sh_dp_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    led_en_d   = '1;
    seg_d      = 7'h7F;
    led_dp_d   = 1'b1;
    scanning_d = 1'b0;
    nib        = 4'h0;
    lz         = 1'b0;

    if (blank) begin
      state_d = IDLE;
    end else if (start) begin
      state_d    = SCAN;
      disp_val_d = value_in;
      disp_dp_d  = dp_in;
      sh_val_d   = value_in;
      sh_dp_d    = dp_in;
      idx_d      = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            cnt_d = '0;
            if (idx_q == IW'(DIGITS - 1)) begin
              // Frame boundary: pick up the latest shadow contents coherently
              idx_d      = '0;
              disp_val_d = sh_val_q;
              disp_dp_d  = sh_dp_q;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
      if (load) begin
        sh_val_d = value_in;
        sh_dp_d  = dp_in;
      end
    end

    if (state_d == SCAN) begin
      scanning_d = 1'b1;
      nib        = disp_val_d[4*32'(idx_d) +: 4];
      lz         = (LZ_BLANK != 0) && lead_zero(disp_val_d, idx_d);
      if (!lz) begin
        led_en_d = ~(DIGITS'(1) << idx_d);
        seg_d    = hex_seg(nib);
        led_dp_d = ~disp_dp_d[idx_d];
      end
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      sh_val_q   <= '0;
      sh_dp_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      led_en     <= '1;
      seg        <= 7'h7F;
      led_dp     <= 1'b1;
      scanning   <= 1'b0;
    end else begin
      state_q    <= state_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      sh_val_q   <= sh_val_d;
      sh_dp_q    <= sh_dp_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      led_en     <= led_en_d;
      seg        <= seg_d;
      led_dp     <= led_dp_d;
      scanning   <= scanning_d;
    end
  end

endmodule
